census_matching_cost: RTL and testbench

CENSUS_MATCHING_COST -- requirements
Module: census_matching_cost

---
 rtl/sgm_pkg.sv | 25 ++
 rtl/census_popcount.sv | 59 +++++
 rtl/census_matching_cost.sv | 183 ++++++++++++++++++
 tb/tb_census_matching_cost.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sgm_pkg.sv
// Shared constants and helpers for the SGM stereo chain (census cost, aggregation).
package sgm_pkg;

  localparam int CENSUS_WIDTH_DEFAULT = 49;
  localparam int MAX_DISP_DEFAULT     = 16;

  // Bits needed to represent values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // LSB position of disparity d inside a packed cost vector.
  function automatic int cost_lsb(input int d, input int cost_width);
    return d * cost_width;
  endfunction

endpackage

// File: rtl/census_popcount.sv
// Two-stage pipelined population count: byte-wise partial sums, then final sum.
module census_popcount
  import sgm_pkg::*;
#(
  parameter  int WIDTH     = CENSUS_WIDTH_DEFAULT,
  localparam int OUT_WIDTH = clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     vec_in,
  output logic [OUT_WIDTH-1:0] count_out
);

  localparam int CHUNK      = 8;
  localparam int NCHUNK     = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PAD_WIDTH  = NCHUNK * CHUNK;
  localparam int PART_WIDTH = 4;

  logic [PAD_WIDTH-1:0]  vec_pad;
  logic [PART_WIDTH-1:0] part_next [NCHUNK];
  logic [PART_WIDTH-1:0] part_reg  [NCHUNK];
  logic [OUT_WIDTH-1:0]  sum_next;
  logic [OUT_WIDTH-1:0]  sum_reg;

  always_comb begin
    vec_pad = '0;
    vec_pad[WIDTH-1:0] = vec_in;
    for (int c = 0; c < NCHUNK; c++) begin
      part_next[c] = '0;
      for (int b = 0; b < CHUNK; b++) begin
        part_next[c] = part_next[c] + PART_WIDTH'(vec_pad[c*CHUNK + b]);
      end
    end
  end

  always_comb begin
    sum_next = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      sum_next = sum_next + OUT_WIDTH'(part_reg[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCHUNK; c++) begin
        part_reg[c] <= '0;
      end
      sum_reg <= '0;
    end else begin
      for (int c = 0; c < NCHUNK; c++) begin
        part_reg[c] <= part_next[c];
      end
      sum_reg <= sum_next;
    end
  end

  assign count_out = sum_reg;

endmodule

// File: rtl/census_matching_cost.sv
// Census Hamming matching cost over MAX_DISP disparities, 3-cycle latency.
// Optional winner-take-all min-tree enabled by macro CENSUS_COST_WTA_EN.
module census_matching_cost
  import sgm_pkg::*;
#(
  parameter  int CENSUS_WIDTH = CENSUS_WIDTH_DEFAULT,
  parameter  int MAX_DISP     = MAX_DISP_DEFAULT,
  localparam int COST_WIDTH   = clog2(CENSUS_WIDTH + 1),
  localparam int DISP_WIDTH   = clog2(MAX_DISP)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           de_in,
  input  logic                           h_sync_in,
  input  logic                           v_sync_in,
  input  logic [CENSUS_WIDTH-1:0]        census_left_in,
  input  logic [CENSUS_WIDTH-1:0]        census_right_in,
  output logic                           de_out,
  output logic                           h_sync_out,
  output logic                           v_sync_out,
  output logic [MAX_DISP*COST_WIDTH-1:0] cost_out
`ifdef CENSUS_COST_WTA_EN
  ,
  output logic [DISP_WIDTH-1:0]          disparity_out
`endif
);

  localparam int COL_WIDTH  = DISP_WIDTH + 1;
  localparam int PIPE_DEPTH = 3;

  logic [CENSUS_WIDTH-1:0]        hist_reg [MAX_DISP-1];
  logic [CENSUS_WIDTH-1:0]        tap      [MAX_DISP];
  logic                           de_prev_reg;
  logic [COL_WIDTH-1:0]           col_reg;
  logic [COL_WIDTH-1:0]           col_idx;
  logic [2:0]                     ctrl_pipe_reg [PIPE_DEPTH];
  logic [MAX_DISP*COST_WIDTH-1:0] cost_s3;

  always_comb begin
    tap[0] = census_right_in;
    for (int d = 1; d < MAX_DISP; d++) begin
      tap[d] = hist_reg[d-1];
    end
  end

  // A rising de_in starts a new line at column 0, even after a mid-line reset.
  assign col_idx = (de_in && !de_prev_reg) ? '0 : col_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_DISP-1; k++) begin
        hist_reg[k] <= '0;
      end
      de_prev_reg <= 1'b0;
      col_reg     <= '0;
    end else begin
      de_prev_reg <= de_in;
      if (de_in) begin
        hist_reg[0] <= census_right_in;
        for (int k = 1; k < MAX_DISP-1; k++) begin
          hist_reg[k] <= hist_reg[k-1];
        end
        col_reg <= (col_idx == COL_WIDTH'(MAX_DISP)) ? col_idx : col_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        ctrl_pipe_reg[k] <= '0;
      end
    end else begin
      ctrl_pipe_reg[0] <= {de_in, h_sync_in, v_sync_in};
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        ctrl_pipe_reg[k] <= ctrl_pipe_reg[k-1];
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < MAX_DISP; gi++) begin : g_disp
    logic [CENSUS_WIDTH-1:0] xor_reg;
    logic [COST_WIDTH-1:0]   cnt;

    // Border pixels feed all-ones so the popcount lands exactly on CENSUS_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        xor_reg <= '0;
      end else begin
        if (gi == 0) begin
          xor_reg <= census_left_in ^ tap[gi];
        end else begin
          xor_reg <= (col_idx < COL_WIDTH'(gi)) ? '1 : (census_left_in ^ tap[gi]);
        end
      end
    end

    census_popcount #(
      .WIDTH(CENSUS_WIDTH)
    ) u_popcount (
      .clk      (clk),
      .rst_n    (rst_n),
      .vec_in   (xor_reg),
      .count_out(cnt)
    );

    assign cost_s3[cost_lsb(gi, COST_WIDTH) +: COST_WIDTH] = cnt;
  end

`ifdef CENSUS_COST_WTA_EN
  logic [MAX_DISP*COST_WIDTH-1:0] cost_dly_reg [DISP_WIDTH];
  logic [2:0]                     ctrl_dly_reg [DISP_WIDTH];

  genvar gj;
  for (gj = 0; gj <= DISP_WIDTH; gj++) begin : g_lvl
    localparam int N = MAX_DISP >> gj;
    logic [N*COST_WIDTH-1:0] cost_lvl;
    logic [N*DISP_WIDTH-1:0] idx_lvl;

    if (gj == 0) begin : g_leaf
      assign cost_lvl = cost_s3;
      always_comb begin
        idx_lvl = '0;
        for (int i = 0; i < N; i++) begin
          idx_lvl[i*DISP_WIDTH +: DISP_WIDTH] = DISP_WIDTH'(i);
        end
      end
    end else begin : g_node
      logic [2*N*COST_WIDTH-1:0] prev_cost;
      logic [2*N*DISP_WIDTH-1:0] prev_idx;
      assign prev_cost = g_lvl[gj-1].cost_lvl;
      assign prev_idx  = g_lvl[gj-1].idx_lvl;

      // Strict less-than keeps the lower disparity on ties.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cost_lvl <= '0;
          idx_lvl  <= '0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (prev_cost[(2*i+1)*COST_WIDTH +: COST_WIDTH] < prev_cost[2*i*COST_WIDTH +: COST_WIDTH]) begin
              cost_lvl[i*COST_WIDTH +: COST_WIDTH] <= prev_cost[(2*i+1)*COST_WIDTH +: COST_WIDTH];
              idx_lvl[i*DISP_WIDTH +: DISP_WIDTH]  <= prev_idx[(2*i+1)*DISP_WIDTH +: DISP_WIDTH];
            end else begin
              cost_lvl[i*COST_WIDTH +: COST_WIDTH] <= prev_cost[2*i*COST_WIDTH +: COST_WIDTH];
              idx_lvl[i*DISP_WIDTH +: DISP_WIDTH]  <= prev_idx[2*i*DISP_WIDTH +: DISP_WIDTH];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DISP_WIDTH; k++) begin
        cost_dly_reg[k] <= '0;
        ctrl_dly_reg[k] <= '0;
      end
    end else begin
      cost_dly_reg[0] <= cost_s3;
      ctrl_dly_reg[0] <= ctrl_pipe_reg[PIPE_DEPTH-1];
      for (int k = 1; k < DISP_WIDTH; k++) begin
        cost_dly_reg[k] <= cost_dly_reg[k-1];
        ctrl_dly_reg[k] <= ctrl_dly_reg[k-1];
      end
    end
  end

  assign cost_out      = cost_dly_reg[DISP_WIDTH-1];
  assign de_out        = ctrl_dly_reg[DISP_WIDTH-1][2];
  assign h_sync_out    = ctrl_dly_reg[DISP_WIDTH-1][1];
  assign v_sync_out    = ctrl_dly_reg[DISP_WIDTH-1][0];
  assign disparity_out = g_lvl[DISP_WIDTH].idx_lvl;
`else
  assign cost_out   = cost_s3;
  assign de_out     = ctrl_pipe_reg[PIPE_DEPTH-1][2];
  assign h_sync_out = ctrl_pipe_reg[PIPE_DEPTH-1][1];
  assign v_sync_out = ctrl_pipe_reg[PIPE_DEPTH-1][0];
`endif

endmodule

// File: tb/tb_census_matching_cost.sv
// Self-checking bench for census_matching_cost: table vectors, directed sequences,
// random lines against a line-position reference model.
module tb_census_matching_cost;

  localparam int CW    = 49;
  localparam int ND    = 16;
  localparam int COSTW = 6;
  localparam int DW    = 4;
  localparam int ALLW  = ND * COSTW;
`ifdef CENSUS_COST_WTA_EN
  localparam int LAT = 3 + DW;
`else
  localparam int LAT = 3;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            de_in = 1'b0;
  logic            h_sync_in = 1'b0;
  logic            v_sync_in = 1'b0;
  logic [CW-1:0]   census_left_in = '0;
  logic [CW-1:0]   census_right_in = '0;
  logic            de_out;
  logic            h_sync_out;
  logic            v_sync_out;
  logic [ALLW-1:0] cost_out;
`ifdef CENSUS_COST_WTA_EN
  logic [DW-1:0]   disparity_out;
`endif

  census_matching_cost dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .de_in          (de_in),
    .h_sync_in      (h_sync_in),
    .v_sync_in      (v_sync_in),
    .census_left_in (census_left_in),
    .census_right_in(census_right_in),
    .de_out         (de_out),
    .h_sync_out     (h_sync_out),
    .v_sync_out     (v_sync_out),
    .cost_out       (cost_out)
`ifdef CENSUS_COST_WTA_EN
    ,
    .disparity_out  (disparity_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      ctrl;
    logic [ALLW-1:0] cost;
    logic [DW-1:0]   disp;
    bit              chk_cost;
    bit              from_tbl;
  } exp_t;

  typedef struct {
    logic [CW-1:0] left;
    logic [CW-1:0] right;
    int            len;
    int            pop;
  } vec_t;

  exp_t          exp_q[$];
  logic [CW-1:0] m_right_q[$];
  int            m_pos;
  bit            m_de_prev;
  int            n_checks = 0;
  int            n_errors = 0;

  function automatic logic [CW-1:0] rnd_cv();
    return CW'({$urandom(), $urandom()});
  endfunction

  // Reference: position in line since the last de rise; tap d is the right
  // vector d valid pixels back; unavailable taps cost the full census width.
  task automatic model_push(input logic [CW-1:0] l, input logic [CW-1:0] r,
                            input logic de, input logic hs, input logic vs,
                            input bit use_tbl, input logic [ALLW-1:0] tbl_cost);
    exp_t e;
    int col;
    int c;
    int best;
    col = (de && !m_de_prev) ? 0 : m_pos;
    e.ctrl = {de, hs, vs};
    e.chk_cost = de;
    e.from_tbl = use_tbl;
    e.cost = '0;
    for (int d = 0; d < ND; d++) begin
      if (col < d) c = CW;
      else if (d == 0) c = $countones(l ^ r);
      else c = $countones(l ^ m_right_q[d-1]);
      e.cost[d*COSTW +: COSTW] = COSTW'(c);
    end
    best = 0;
    for (int d = 1; d < ND; d++) begin
      if (e.cost[d*COSTW +: COSTW] < e.cost[best*COSTW +: COSTW]) best = d;
    end
    e.disp = DW'(best);
    if (use_tbl) begin
      e.cost = tbl_cost;
      e.disp = '0;
    end
    if (de) begin
      m_right_q.push_front(r);
      if (m_right_q.size() > ND) void'(m_right_q.pop_back());
      m_pos = col + 1;
    end
    m_de_prev = de;
    exp_q.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    if (exp_q.size() < LAT) return;
    e = exp_q.pop_front();
    n_checks++;
    if ({de_out, h_sync_out, v_sync_out} !== e.ctrl) begin
      n_errors++;
      $display("FAIL ctrl: got %b want %b", {de_out, h_sync_out, v_sync_out}, e.ctrl);
    end
    if (e.chk_cost) begin
      n_checks++;
      if (cost_out !== e.cost) begin
        n_errors++;
        $display("FAIL %s: got %h want %h", e.from_tbl ? "tbl_cost" : "cost", cost_out, e.cost);
      end
`ifdef CENSUS_COST_WTA_EN
      n_checks++;
      if (disparity_out !== e.disp) begin
        n_errors++;
        $display("FAIL disparity: got %0d want %0d", disparity_out, e.disp);
      end
`endif
    end
  endtask

  task automatic cycle(input logic [CW-1:0] l, input logic [CW-1:0] r,
                       input logic de, input logic hs, input logic vs,
                       input bit use_tbl = 1'b0, input logic [ALLW-1:0] tbl_cost = '0);
    @(negedge clk);
    check_front();
    census_left_in  = l;
    census_right_in = r;
    de_in           = de;
    h_sync_in       = hs;
    v_sync_in       = vs;
    model_push(l, r, de, hs, vs, use_tbl, tbl_cost);
  endtask

  task automatic do_reset();
    exp_t z;
    logic [ALLW+2:0] outs;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs = {de_out, h_sync_out, v_sync_out, cost_out};
    n_checks++;
`ifdef CENSUS_COST_WTA_EN
    if (outs !== '0 || disparity_out !== '0) begin
      n_errors++;
      $display("FAIL reset_out: got %h/%0d want 0/0", outs, disparity_out);
    end
`else
    if (outs !== '0) begin
      n_errors++;
      $display("FAIL reset_out: got %h want 0", outs);
    end
`endif
    census_left_in  = '0;
    census_right_in = '0;
    de_in           = 1'b0;
    h_sync_in       = 1'b0;
    v_sync_in       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_right_q.delete();
    m_pos     = 0;
    m_de_prev = 1'b0;
    z.ctrl = '0;
    z.cost = '0;
    z.disp = '0;
    z.chk_cost = 1'b1;
    z.from_tbl = 1'b0;
    for (int k = 0; k < LAT - 1; k++) exp_q.push_back(z);
    model_push('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic line_gap(input int n);
    for (int g = 0; g < n; g++) cycle(rnd_cv(), rnd_cv(), 1'b0, g == 0, 1'b0);
  endtask

  initial begin
    vec_t            tbl [6];
    logic [ALLW-1:0] tc;
    logic [CW-1:0]   s [45];
    int              len;

    tbl[0] = '{49'h1_5555_5555_5555, 49'h1_5555_5555_5555, 20, 0};
    tbl[1] = '{49'h1_FFFF_FFFF_FFFF, 49'h0,                20, 49};
    tbl[2] = '{49'h1_FFFF_FFFF_FFFF, 49'h0,                4,  49};
    tbl[3] = '{49'h0_0000_0000_000F, 49'h0,                4,  4};
    tbl[4] = '{49'h0_0000_0000_00FF, 49'h0_0000_0000_00F0, 10, 4};
    tbl[5] = '{49'h1_FFFF_FFFF_FFFF, 49'h1_5555_5555_5555, 18, 24};

    do_reset();

    for (int t = 0; t < 6; t++) begin
      $display("table vector %0d: len %0d expected cost %0d", t, tbl[t].len, tbl[t].pop);
      for (int g = 0; g < 3; g++) cycle('0, '0, 1'b0, g == 0, t == 0 && g == 0);
      tc = '0;
      for (int d = 0; d < ND; d++) tc[d*COSTW +: COSTW] = COSTW'((d <= tbl[t].len - 1) ? tbl[t].pop : CW);
      for (int x = 0; x < tbl[t].len; x++)
        cycle(tbl[t].left, tbl[t].right, 1'b1, 1'b0, 1'b0, x == tbl[t].len - 1, tc);
    end

    $display("sequence: right leads left by 5 pixels");
    for (int i = 0; i < 45; i++) s[i] = rnd_cv();
    line_gap(3);
    for (int x = 0; x < 35; x++) cycle(s[x], s[x+5], 1'b1, 1'b0, 1'b0);

    $display("sequence: 10-cycle de gap mid-line");
    line_gap(3);
    for (int x = 0; x < 30; x++) begin
      if (x == 12) for (int g = 0; g < 10; g++) cycle(rnd_cv(), rnd_cv(), 1'b0, 1'b0, 1'b0);
      cycle(rnd_cv(), rnd_cv(), 1'b1, 1'b0, 1'b0);
    end

    for (int ln = 0; ln < 20; ln++) begin
      len = $urandom_range(5, 40);
      $display("random line %0d: %0d pixels", ln, len);
      line_gap($urandom_range(1, 4));
      for (int x = 0; x < len; x++)
        cycle(rnd_cv(), rnd_cv(), ($urandom % 8) != 0, 1'b0, ($urandom % 16) == 0);
    end

    $display("sequence: reset mid-line, line continues after release");
    line_gap(2);
    for (int x = 0; x < 10; x++) cycle(rnd_cv(), rnd_cv(), 1'b1, 1'b0, 1'b0);
    do_reset();
    for (int x = 0; x < 20; x++) cycle(rnd_cv(), rnd_cv(), 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < LAT + 2; k++) cycle('0, '0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
